// File: rtl/cm138_pkg.sv
// cm138_pkg: shared types and constants for the cm138 line encoder.
//   state_t      - encoder FSM states (IDLE, EMIT, GAP)
//   NUM_LINES    - number of active-low select lines
//   CODE_W       - width of the encoded index
//   STRETCH_MAX  - largest supported idle gap between codes
//   GAP_W        - width of the gap down-counter
package cm138_pkg;

  localparam int unsigned NUM_LINES   = 8;
  localparam int unsigned CODE_W      = 3;
  localparam int unsigned STRETCH_MAX = 15;
  localparam int unsigned GAP_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/cm138_pick.sv
// cm138_pick: combinational selector returning the first set bit of pend,
// searching upward (with wrap) from index start.
//   pend  - pending request bits
//   start - index the search begins at
//   idx   - selected index (0 when nothing is pending)
//   any   - high when pend has at least one bit set
module cm138_pick
  import cm138_pkg::*;
(
  input  logic [NUM_LINES-1:0] pend,
  input  logic [CODE_W-1:0]    start,
  output logic [CODE_W-1:0]    idx,
  output logic                 any
);

  logic [CODE_W-1:0] cand;

  // Walk from the farthest offset down so the nearest hit wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      cand = start + CODE_W'(i);
      if (pend[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cm138_encoder.sv
// cm138_encoder: captures active-low select lines on a sample strobe and
// emits the index of every requested line, one code per valid/ready handshake,
// optionally separated by STRETCH idle cycles.
// Optional feature: define CM138_ENCODER_RR_EN for round-robin selection
// (search starts just after the last accepted index); default is fixed
// lowest-index priority.
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_n       - active-low select lines, bit k low requests code k
//   sample      - capture strobe for req_n (honoured only when idle)
//   code        - encoded index
//   code_valid  - code is valid
//   code_ready  - consumer accepts code
//   busy        - encoder is not idle
//   overrun     - one-cycle pulse: a sample arrived while busy and was dropped
module cm138_encoder
  import cm138_pkg::*;
#(
  parameter int unsigned STRETCH = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LINES-1:0] req_n,
  input  logic                 sample,
  output logic [CODE_W-1:0]    code,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [GAP_W-1:0] STRETCH_C =
    (STRETCH > STRETCH_MAX) ? GAP_W'(STRETCH_MAX) : GAP_W'(STRETCH);

  state_t                state_q, state_d;
  logic [NUM_LINES-1:0]  pend_q, pend_d, pend_left, pick_pend;
  logic [CODE_W-1:0]     code_q, code_d, pick_start, pick_idx;
  logic                  valid_q, valid_d;
  logic                  busy_q, overrun_q, overrun_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  pick_any, accept;

  assign accept = valid_q && code_ready;

`ifdef CM138_ENCODER_RR_EN
  logic [CODE_W-1:0] ptr_q;

  // Pointer to the index after the last accepted code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= code_q + CODE_W'(1);
    end
  end

  // The pick on an accepting edge must already see the advanced pointer.
  assign pick_start = accept ? code_q + CODE_W'(1) : ptr_q;
`else
  assign pick_start = '0;
`endif

  // Pending set the selector looks at for the next code.
  always_comb begin
    pend_left         = pend_q;
    pend_left[code_q] = 1'b0;
    pick_pend         = pend_q;
    case (state_q)
      IDLE:    pick_pend = ~req_n;
      EMIT:    pick_pend = pend_left;
      default: pick_pend = pend_q;
    endcase
  end

  cm138_pick u_pick (
    .pend  (pick_pend),
    .start (pick_start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    code_d    = code_q;
    valid_d   = valid_q;
    gap_d     = gap_q;
    overrun_d = sample && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (sample) begin
          pend_d = ~req_n;
          if (pick_any) begin
            state_d = EMIT;
            code_d  = pick_idx;
            valid_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (accept) begin
          pend_d = pend_left;
          if (!pick_any) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else if (STRETCH_C == '0) begin
            code_d = pick_idx;
          end else begin
            state_d = GAP;
            valid_d = 1'b0;
            gap_d   = STRETCH_C;
          end
        end
      end
      GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          state_d = EMIT;
          code_d  = pick_idx;
          valid_d = 1'b1;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      busy_q    <= (state_d != IDLE);
      overrun_q <= overrun_d;
      gap_q     <= gap_d;
    end
  end

  assign code       = code_q;
  assign code_valid = valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cm138_encoder.sv
// tb_cm138_encoder: drives two encoders (STRETCH=0 and STRETCH=3) from shared
// inputs, checks both against a behavioural model every cycle, and pins the
// model with hand-computed scenario expectations.
module tb_cm138_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_n = 8'hFF;
  logic       sample = 1'b0;
  logic       code_ready = 1'b0;
  logic [2:0] code_o [2];
  logic       valid_o [2];
  logic       busy_o [2];
  logic       ovr_o [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cm138_encoder #(.STRETCH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_n(req_n), .sample(sample),
    .code(code_o[0]), .code_valid(valid_o[0]), .code_ready(code_ready),
    .busy(busy_o[0]), .overrun(ovr_o[0])
  );

  cm138_encoder #(.STRETCH(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_n(req_n), .sample(sample),
    .code(code_o[1]), .code_valid(valid_o[1]), .code_ready(code_ready),
    .busy(busy_o[1]), .overrun(ovr_o[1])
  );

  // ---------------- behavioural model ----------------
  bit [7:0] m_pend [2];
  int       m_code [2];
  bit       m_valid [2];
  bit       m_busy [2];
  bit       m_ovr [2];
  int       m_gap [2];
  int       m_ptr [2];

  function automatic int stretch_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  // First pending line found walking upward (mod 8) from the start point.
  function automatic int next_code(input bit [7:0] p, input int ptr);
    int s;
`ifdef CM138_ENCODER_RR_EN
    s = ptr;
`else
    s = 0 * ptr;
`endif
    for (int k = 0; k < 8; k++) begin
      if (p[(s + k) % 8]) return (s + k) % 8;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pend[i] = 0; m_code[i] = 0; m_valid[i] = 0; m_busy[i] = 0;
        m_ovr[i] = 0; m_gap[i] = 0; m_ptr[i] = 0;
      end else begin
        m_ovr[i] = sample && m_busy[i];
        if (!m_busy[i]) begin
          if (sample) begin
            m_pend[i] = ~req_n;
            if (m_pend[i] != 0) begin
              m_busy[i]  = 1;
              m_valid[i] = 1;
              m_code[i]  = next_code(m_pend[i], m_ptr[i]);
            end
          end
        end else if (m_valid[i]) begin
          if (code_ready) begin
            m_pend[i][m_code[i]] = 1'b0;
            m_ptr[i] = (m_code[i] + 1) % 8;
            if (m_pend[i] == 0) begin
              m_busy[i] = 0; m_valid[i] = 0;
            end else if (stretch_of(i) == 0) begin
              m_code[i] = next_code(m_pend[i], m_ptr[i]);
            end else begin
              m_valid[i] = 0; m_gap[i] = stretch_of(i);
            end
          end
        end else begin
          m_gap[i]--;
          if (m_gap[i] == 0) begin
            m_valid[i] = 1;
            m_code[i]  = next_code(m_pend[i], m_ptr[i]);
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  int acc0[$], acc1[$], vh0[$], vh1[$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid[%0d]", i), int'(valid_o[i]), int'(m_valid[i]));
      chk($sformatf("busy[%0d]", i), int'(busy_o[i]), int'(m_busy[i]));
      chk($sformatf("overrun[%0d]", i), int'(ovr_o[i]), int'(m_ovr[i]));
      if (m_valid[i] || !rst_n)
        chk($sformatf("code[%0d]", i), int'(code_o[i]), m_code[i]);
    end
    if (valid_o[0] && code_ready) acc0.push_back(int'(code_o[0]));
    if (valid_o[1] && code_ready) acc1.push_back(int'(code_o[1]));
    vh0.push_back(int'(valid_o[0]));
    vh1.push_back(int'(valid_o[1]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc0.delete(); acc1.delete(); vh0.delete(); vh1.delete();
  endtask

  task automatic do_reset();
    sample = 0; code_ready = 0; req_n = 8'hFF;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic capture(input logic [7:0] r);
    req_n = r; sample = 1;
    tick();
    sample = 0;
    clear_logs();
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_code[%0d]", tag, i), int'(code_o[i]), 0);
      chk($sformatf("%s_valid[%0d]", tag, i), int'(valid_o[i]), 0);
      chk($sformatf("%s_busy[%0d]", tag, i), int'(busy_o[i]), 0);
      chk($sformatf("%s_ovr[%0d]", tag, i), int'(ovr_o[i]), 0);
    end
  endtask

  int r;

  initial begin
    // Reset state
    rst_n = 0;
    tick();
    @(negedge clk);
    check_all_zero("reset");
    do_reset();

    // Scenario 1: 8'hDB -> codes 2 then 5 back to back
    code_ready = 1;
    capture(8'hDB);
    repeat (8) tick();
    chk("s1_n", acc0.size(), 2);
    chk("s1_c0", qat(acc0, 0), 2);
    chk("s1_c1", qat(acc0, 1), 5);
    chk("s1_v0", qat(vh0, 0), 1);
    chk("s1_v1", qat(vh0, 1), 1);
    chk("s1_v2", qat(vh0, 2), 0);
    chk("s1_busy", int'(busy_o[0]), 0);
    chk("s1_st3_n", acc1.size(), 2);

    // Scenario 2: 8'h7F held 4 cycles, accepted on the 5th
    do_reset();
    code_ready = 0;
    capture(8'h7F);
    repeat (4) begin
      @(negedge clk);
      chk("s2_hold_code", int'(code_o[0]), 7);
      tick();
    end
    code_ready = 1;
    repeat (3) tick();
    chk("s2_n", acc0.size(), 1);
    chk("s2_c0", qat(acc0, 0), 7);
    chk("s2_vcnt", int'(vh0.sum() with (item)), 5);
    chk("s2_after", qat(vh0, 5), 0);

    // Scenario 3: STRETCH=3 on 8'hFC -> code 0, 3 idle cycles, code 1
    do_reset();
    code_ready = 1;
    capture(8'hFC);
    repeat (8) tick();
    chk("s3_v0", qat(vh1, 0), 1);
    chk("s3_v1", qat(vh1, 1), 0);
    chk("s3_v2", qat(vh1, 2), 0);
    chk("s3_v3", qat(vh1, 3), 0);
    chk("s3_v4", qat(vh1, 4), 1);
    chk("s3_v5", qat(vh1, 5), 0);
    chk("s3_c0", qat(acc1, 0), 0);
    chk("s3_c1", qat(acc1, 1), 1);

    // Scenario 4: sample while busy -> one overrun pulse, sequence unchanged
    do_reset();
    code_ready = 0;
    capture(8'hDB);
    tick();
    req_n = 8'h00; sample = 1;
    tick();
    sample = 0;
    @(negedge clk);
    chk("s4_ovr_hi", int'(ovr_o[0]), 1);
    tick();
    @(negedge clk);
    chk("s4_ovr_lo", int'(ovr_o[0]), 0);
    code_ready = 1;
    repeat (10) tick();
    chk("s4_n", acc0.size(), 2);
    chk("s4_c0", qat(acc0, 0), 2);
    chk("s4_c1", qat(acc0, 1), 5);

    // Scenario 5: reset mid-EMIT, then an all-idle sample does nothing
    do_reset();
    code_ready = 0;
    capture(8'h0F);
    tick();
    rst_n = 0;
    @(negedge clk);
    check_all_zero("s5_rst");
    tick();
    rst_n = 1;
    tick();
    capture(8'hFF);
    repeat (3) tick();
    chk("s5_n", acc0.size(), 0);
    chk("s5_busy", int'(busy_o[0]), 0);
    chk("s5_valid", int'(valid_o[0]), 0);

`ifdef CM138_ENCODER_RR_EN
    // Scenario 6: pointer persists across samples
    do_reset();
    code_ready = 1;
    capture(8'hFD);
    repeat (3) tick();
    chk("s6_first", qat(acc0, 0), 1);
    capture(8'hFC);
    repeat (4) tick();
    chk("s6_c0", qat(acc0, 0), 0);
    chk("s6_c1", qat(acc0, 1), 1);
    capture(8'hFA);
    repeat (4) tick();
    chk("s6_rr0", qat(acc0, 0), 2);
    chk("s6_rr1", qat(acc0, 1), 0);
`endif

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      sample = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 7));
      if (r == 0) req_n = 8'hFF;
      else if (r == 1) req_n = 8'h00;
      else req_n = 8'($urandom);
      code_ready = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1;
    sample = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
